id_ex_reg: RTL and testbench
============================

# id_ex_reg

ID/EX pipeline register for the five-stage RISC-V core. It captures decoded control, operands, immediate and register indices from ID each cycle and presents them to EX. It inserts a bubble on request from the hazard/stall unit, clears on a taken branch/jump flush, and freezes under a downstream hold. Its `mem_rd_o` and `rd_o` outputs feed back to the hazard/stall unit's load-use comparison.

## Interface
Parameters:
- `XLEN`, 32, datapath width (PC, operands, immediate).

Ports:
- `clk_i`  in  1  core clock; all state updates on the rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `bubble_i`  in  1  insert a NOP into EX this cycle; this is the hazard unit's bubble/reset request.
- `flush_i`  in  1  taken branch/jump resolved in EX; discard the instruction being loaded.
- `hold_i`  in  1  freeze register contents (EX/MEM stalled downstream).
- `valid_i`  in  1  ID holds a real instruction.
- `reg_wr_i`, `mem_rd_i`, `mem_wr_i`, `mem2reg_i`, `alu_src_i`, `branch_i`, `jump_i`  in  1 each  decoded control bits.
- `alu_op_i`  in  3  ALU operation class.
- `funct3_i`  in  3  instruction funct3.
- `pc_i`, `rs1_data_i`, `rs2_data_i`, `imm_i`  in  XLEN each  PC, register-file read data, immediate.
- `rs1_i`, `rs2_i`, `rd_i`  in  5 each  register indices.
- `*_o`  out  (same widths)  registered copy of every `*_i` above except `bubble_i`, `flush_i` and `hold_i`; includes `valid_o`.
- `bubble_cnt_o`, `flush_cnt_o`  out  16 each  performance counters (see Configuration).

## Operation
- Register update priority, evaluated at each rising edge: `reset_i` > `flush_i` > `hold_i` > `bubble_i` > load.
- Reset: every output is 0. The counters are also cleared.
- Flush: every output is 0 (NOP). `flush_i` overrides `hold_i`.
- Hold: all outputs keep their previous values. A `bubble_i` asserted in the same cycle is ignored, because upstream is frozen too and re-presents the same instruction.
- Bubble: every output is 0, including `rd_o` = 0, so that neither forwarding nor the hazard compare matches. The ID instruction is not lost: the hazard unit holds PC and IF/ID, so ID re-presents it next cycle.
- Load: all `*_o` take their `*_i` values.
- Load with `valid_i` = 0: all control outputs and `rd_o` are forced to 0. Data fields still load.
- Invariant: whenever `valid_o` = 0, then `reg_wr_o`, `mem_rd_o`, `mem_wr_o`, `branch_o`, `jump_o` and `rd_o` are all 0.
- No combinational path from any input to any output.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- Load-use hazard, with a load in ID/EX and its consumer in ID:
  - Cycle N: the hazard unit sees `mem_rd_o`=1 and a matching `rd_o`, and asserts `bubble_i`.
  - Edge N+1: a NOP enters EX.
  - Cycle N+1: `mem_rd_o`=0, so `bubble_i` drops.
  - Edge N+2: the consumer loads.
  - Result: exactly one bubble per load-use hazard. Do not add any latching of `bubble_i`.
- Consecutive `bubble_i` cycles each insert one NOP.
- `reset_i` asserted mid-operation clears state at the next edge, regardless of `hold_i`.
- Deasserting reset: the first load happens on the first edge with `reset_i`=0.

## Configuration
- Macro `ID_EX_PERF_EN`.
- Defined:
  - `bubble_cnt_o` increments on every edge where a bubble is actually inserted, i.e. `bubble_i`=1 and not reset, flush or hold.
  - `flush_cnt_o` increments on every edge where `flush_i`=1 and `reset_i`=0.
  - Both counters saturate at 16'hFFFF and clear on reset.
- Undefined: both ports exist and are tied to 16'h0000, and no counter flops are synthesized.

## Test plan
- Reset: with `reset_i`=1 for 2 cycles and all inputs = random, every output = 0 after the first edge.
- Load: `pc_i`=32'h0000_0040, `rd_i`=5, `reg_wr_i`=1, `valid_i`=1 → the next cycle shows `pc_o`=32'h40, `rd_o`=5, `reg_wr_o`=1, `valid_o`=1.
- Load-use bubble: after loading `mem_rd_i`=1, `rd_i`=7, pulse `bubble_i` for 1 cycle → next cycle `rd_o`=0 and `mem_rd_o`=0; the following load shows the new inputs. With `ID_EX_PERF_EN`, `bubble_cnt_o`=1.
- Hold vs bubble vs flush:
  - `hold_i`=1 and `bubble_i`=1 → outputs are unchanged and `bubble_cnt_o` is unchanged.
  - `hold_i`=1 and `flush_i`=1 → all outputs 0 and `flush_cnt_o`=1.
- Invalid load: `valid_i`=0 with `mem_wr_i`=1, `rd_i`=9, `imm_i`=32'h123 → `mem_wr_o`=0, `rd_o`=0, `imm_o`=32'h123.
- Saturation (`ID_EX_PERF_EN`): 70000 consecutive bubbles → `bubble_cnt_o`=16'hFFFF and it stays there; reset then returns it to 0.

Source files
------------

// File: rtl/id_ex_reg_if.sv
// rtl/id_ex_reg_if.sv - ID-side inputs and EX-side outputs of the ID/EX pipeline register
interface id_ex_reg_if #(
  parameter int XLEN = 32
);
  logic            valid_i,    valid_o;
  logic            reg_wr_i,   reg_wr_o;
  logic            mem_rd_i,   mem_rd_o;
  logic            mem_wr_i,   mem_wr_o;
  logic            mem2reg_i,  mem2reg_o;
  logic            alu_src_i,  alu_src_o;
  logic            branch_i,   branch_o;
  logic            jump_i,     jump_o;
  logic [2:0]      alu_op_i,   alu_op_o;
  logic [2:0]      funct3_i,   funct3_o;
  logic [XLEN-1:0] pc_i,       pc_o;
  logic [XLEN-1:0] rs1_data_i, rs1_data_o;
  logic [XLEN-1:0] rs2_data_i, rs2_data_o;
  logic [XLEN-1:0] imm_i,      imm_o;
  logic [4:0]      rs1_i,      rs1_o;
  logic [4:0]      rs2_i,      rs2_o;
  logic [4:0]      rd_i,       rd_o;

  // master: ID stage driving the register and EX/hazard logic reading it
  modport master (
    output valid_i, reg_wr_i, mem_rd_i, mem_wr_i, mem2reg_i, alu_src_i, branch_i, jump_i,
           alu_op_i, funct3_i, pc_i, rs1_data_i, rs2_data_i, imm_i, rs1_i, rs2_i, rd_i,
    input  valid_o, reg_wr_o, mem_rd_o, mem_wr_o, mem2reg_o, alu_src_o, branch_o, jump_o,
           alu_op_o, funct3_o, pc_o, rs1_data_o, rs2_data_o, imm_o, rs1_o, rs2_o, rd_o
  );

  modport slave (
    input  valid_i, reg_wr_i, mem_rd_i, mem_wr_i, mem2reg_i, alu_src_i, branch_i, jump_i,
           alu_op_i, funct3_i, pc_i, rs1_data_i, rs2_data_i, imm_i, rs1_i, rs2_i, rd_i,
    output valid_o, reg_wr_o, mem_rd_o, mem_wr_o, mem2reg_o, alu_src_o, branch_o, jump_o,
           alu_op_o, funct3_o, pc_o, rs1_data_o, rs2_data_o, imm_o, rs1_o, rs2_o, rd_o
  );
endinterface

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with bubble, flush and hold
// Optional performance counters enabled by macro ID_EX_PERF_EN.
module id_ex_reg #(
  parameter int XLEN = 32
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        bubble_i,
  input  logic        flush_i,
  input  logic        hold_i,
  id_ex_reg_if.slave  bus,
  output logic [15:0] bubble_cnt_o,
  output logic [15:0] flush_cnt_o
);

  logic clear;
  logic ctl_en;

  // reset > flush > hold > bubble > load
  assign clear  = reset_i || flush_i || (!hold_i && bubble_i);
  assign ctl_en = bus.valid_i;

  always_ff @(posedge clk_i) begin
    if (clear) begin
      bus.valid_o    <= 1'b0;
      bus.reg_wr_o   <= 1'b0;
      bus.mem_rd_o   <= 1'b0;
      bus.mem_wr_o   <= 1'b0;
      bus.mem2reg_o  <= 1'b0;
      bus.alu_src_o  <= 1'b0;
      bus.branch_o   <= 1'b0;
      bus.jump_o     <= 1'b0;
      bus.alu_op_o   <= 3'd0;
      bus.funct3_o   <= 3'd0;
      bus.pc_o       <= '0;
      bus.rs1_data_o <= '0;
      bus.rs2_data_o <= '0;
      bus.imm_o      <= '0;
      bus.rs1_o      <= 5'd0;
      bus.rs2_o      <= 5'd0;
      bus.rd_o       <= 5'd0;
    end else if (!hold_i) begin
      // an invalid slot carries its data but can never write, access memory or redirect
      bus.valid_o    <= bus.valid_i;
      bus.reg_wr_o   <= bus.reg_wr_i  && ctl_en;
      bus.mem_rd_o   <= bus.mem_rd_i  && ctl_en;
      bus.mem_wr_o   <= bus.mem_wr_i  && ctl_en;
      bus.mem2reg_o  <= bus.mem2reg_i && ctl_en;
      bus.alu_src_o  <= bus.alu_src_i && ctl_en;
      bus.branch_o   <= bus.branch_i  && ctl_en;
      bus.jump_o     <= bus.jump_i    && ctl_en;
      bus.alu_op_o   <= ctl_en ? bus.alu_op_i : 3'd0;
      bus.funct3_o   <= bus.funct3_i;
      bus.pc_o       <= bus.pc_i;
      bus.rs1_data_o <= bus.rs1_data_i;
      bus.rs2_data_o <= bus.rs2_data_i;
      bus.imm_o      <= bus.imm_i;
      bus.rs1_o      <= bus.rs1_i;
      bus.rs2_o      <= bus.rs2_i;
      bus.rd_o       <= ctl_en ? bus.rd_i : 5'd0;
    end
  end

`ifdef ID_EX_PERF_EN
  logic [15:0] bubble_cnt;
  logic [15:0] flush_cnt;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bubble_cnt <= 16'h0000;
      flush_cnt  <= 16'h0000;
    end else begin
      if (flush_i && flush_cnt != 16'hFFFF)
        flush_cnt <= flush_cnt + 16'd1;
      if (bubble_i && !flush_i && !hold_i && bubble_cnt != 16'hFFFF)
        bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

  assign bubble_cnt_o = bubble_cnt;
  assign flush_cnt_o  = flush_cnt;
`else
  assign bubble_cnt_o = 16'h0000;
  assign flush_cnt_o  = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - directed self-checking bench for id_ex_reg
module tb_id_ex_reg;
  localparam int XLEN = 32;
`ifdef ID_EX_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i, bubble_i, flush_i, hold_i;
  logic [15:0] bubble_cnt_o, flush_cnt_o;
  logic [15:0] exp_b, exp_f;
  int          n_run = 0;
  int          n_fail = 0;

  id_ex_reg_if #(.XLEN(XLEN)) bus ();

  id_ex_reg #(.XLEN(XLEN)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .bubble_i     (bubble_i),
    .flush_i      (flush_i),
    .hold_i       (hold_i),
    .bus          (bus),
    .bubble_cnt_o (bubble_cnt_o),
    .flush_cnt_o  (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  wire [4*XLEN+3*5+2*3+8-1:0] out_vec = {
    bus.valid_o, bus.reg_wr_o, bus.mem_rd_o, bus.mem_wr_o, bus.mem2reg_o,
    bus.alu_src_o, bus.branch_o, bus.jump_o, bus.alu_op_o, bus.funct3_o,
    bus.pc_o, bus.rs1_data_o, bus.rs2_data_o, bus.imm_o, bus.rs1_o, bus.rs2_o, bus.rd_o};

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    bus.valid_i = 0; bus.reg_wr_i = 0; bus.mem_rd_i = 0; bus.mem_wr_i = 0;
    bus.mem2reg_i = 0; bus.alu_src_i = 0; bus.branch_i = 0; bus.jump_i = 0;
    bus.alu_op_i = 0; bus.funct3_i = 0; bus.pc_i = 0; bus.rs1_data_i = 0;
    bus.rs2_data_i = 0; bus.imm_i = 0; bus.rs1_i = 0; bus.rs2_i = 0; bus.rd_i = 0;
  endtask

  task automatic random_inputs();
    bus.valid_i = 1'($urandom); bus.reg_wr_i = 1'($urandom); bus.mem_rd_i = 1'($urandom);
    bus.mem_wr_i = 1'($urandom); bus.mem2reg_i = 1'($urandom); bus.alu_src_i = 1'($urandom);
    bus.branch_i = 1'($urandom); bus.jump_i = 1'($urandom); bus.alu_op_i = 3'($urandom);
    bus.funct3_i = 3'($urandom); bus.pc_i = $urandom; bus.rs1_data_i = $urandom;
    bus.rs2_data_i = $urandom; bus.imm_i = $urandom; bus.rs1_i = 5'($urandom);
    bus.rs2_i = 5'($urandom); bus.rd_i = 5'($urandom);
  endtask

  task automatic test_reset();
    random_inputs();
    reset_i = 1; bubble_i = 1'($urandom); flush_i = 1'($urandom); hold_i = 1'($urandom);
    tick();
    n_run++;
    if (out_vec !== '0) begin
      n_fail++; $display("FAIL reset_outputs got %h want 0", out_vec);
    end
    n_run++;
    if (bubble_cnt_o !== 16'h0 || flush_cnt_o !== 16'h0) begin
      n_fail++; $display("FAIL reset_counters got %h/%h want 0/0", bubble_cnt_o, flush_cnt_o);
    end
    tick();
    reset_i = 0; bubble_i = 0; flush_i = 0; hold_i = 0;
    clear_inputs();
    exp_b = 0; exp_f = 0;
  endtask

  task automatic test_load();
    bus.pc_i = 32'h0000_0040; bus.rd_i = 5'd5; bus.reg_wr_i = 1; bus.valid_i = 1;
    bus.rs1_data_i = 32'hDEAD_BEEF; bus.alu_op_i = 3'd6;
    tick();
    n_run++;
    if (bus.pc_o !== 32'h40 || bus.rd_o !== 5'd5 || bus.reg_wr_o !== 1'b1 || bus.valid_o !== 1'b1) begin
      n_fail++; $display("FAIL load pc=%h rd=%0d reg_wr=%b valid=%b want 40/5/1/1",
                         bus.pc_o, bus.rd_o, bus.reg_wr_o, bus.valid_o);
    end
    n_run++;
    if (bus.rs1_data_o !== 32'hDEAD_BEEF || bus.alu_op_o !== 3'd6 || bus.mem_rd_o !== 1'b0) begin
      n_fail++; $display("FAIL load_fields rs1_data=%h alu_op=%0d mem_rd=%b want deadbeef/6/0",
                         bus.rs1_data_o, bus.alu_op_o, bus.mem_rd_o);
    end
  endtask

  task automatic test_bubble();
    clear_inputs();
    bus.valid_i = 1; bus.mem_rd_i = 1; bus.mem2reg_i = 1; bus.reg_wr_i = 1; bus.rd_i = 5'd7;
    bus.pc_i = 32'h48;
    tick();
    n_run++;
    if (bus.mem_rd_o !== 1'b1 || bus.rd_o !== 5'd7) begin
      n_fail++; $display("FAIL bubble_load mem_rd=%b rd=%0d want 1/7", bus.mem_rd_o, bus.rd_o);
    end
    bubble_i = 1;
    bus.pc_i = 32'h4C; bus.rd_i = 5'd8; bus.mem_rd_i = 0; bus.mem2reg_i = 0; bus.rs1_i = 5'd7;
    tick();
    exp_b++;
    n_run++;
    if (bus.rd_o !== 5'd0 || bus.mem_rd_o !== 1'b0 || bus.valid_o !== 1'b0 || out_vec !== '0) begin
      n_fail++; $display("FAIL bubble_nop rd=%0d mem_rd=%b valid=%b want 0/0/0",
                         bus.rd_o, bus.mem_rd_o, bus.valid_o);
    end
    n_run++;
    if (bubble_cnt_o !== (PERF ? exp_b : 16'h0)) begin
      n_fail++; $display("FAIL bubble_cnt got %0d want %0d", bubble_cnt_o, PERF ? exp_b : 16'h0);
    end
    bubble_i = 0;
    tick();
    n_run++;
    if (bus.pc_o !== 32'h4C || bus.rd_o !== 5'd8 || bus.rs1_o !== 5'd7 || bus.reg_wr_o !== 1'b1) begin
      n_fail++; $display("FAIL bubble_reload pc=%h rd=%0d rs1=%0d want 4c/8/7",
                         bus.pc_o, bus.rd_o, bus.rs1_o);
    end
  endtask

  task automatic test_hold_bubble();
    hold_i = 1; bubble_i = 1;
    bus.pc_i = 32'h100; bus.rd_i = 5'd3;
    tick();
    tick();
    n_run++;
    if (bus.pc_o !== 32'h4C || bus.rd_o !== 5'd8 || bus.valid_o !== 1'b1) begin
      n_fail++; $display("FAIL hold_bubble pc=%h rd=%0d valid=%b want 4c/8/1",
                         bus.pc_o, bus.rd_o, bus.valid_o);
    end
    n_run++;
    if (bubble_cnt_o !== (PERF ? exp_b : 16'h0)) begin
      n_fail++; $display("FAIL hold_bubble_cnt got %0d want %0d", bubble_cnt_o, PERF ? exp_b : 16'h0);
    end
    bubble_i = 0;
  endtask

  task automatic test_hold_flush();
    hold_i = 1; flush_i = 1;
    tick();
    exp_f++;
    n_run++;
    if (out_vec !== '0) begin
      n_fail++; $display("FAIL hold_flush got %h want 0", out_vec);
    end
    n_run++;
    if (flush_cnt_o !== (PERF ? exp_f : 16'h0)) begin
      n_fail++; $display("FAIL flush_cnt got %0d want %0d", flush_cnt_o, PERF ? exp_f : 16'h0);
    end
    hold_i = 0; flush_i = 0;
  endtask

  task automatic test_invalid();
    clear_inputs();
    bus.valid_i = 0; bus.mem_wr_i = 1; bus.reg_wr_i = 1; bus.jump_i = 1;
    bus.rd_i = 5'd9; bus.imm_i = 32'h123; bus.rs2_i = 5'd4;
    tick();
    n_run++;
    if (bus.mem_wr_o !== 1'b0 || bus.rd_o !== 5'd0 || bus.imm_o !== 32'h123) begin
      n_fail++; $display("FAIL invalid mem_wr=%b rd=%0d imm=%h want 0/0/123",
                         bus.mem_wr_o, bus.rd_o, bus.imm_o);
    end
    n_run++;
    if (bus.reg_wr_o !== 1'b0 || bus.jump_o !== 1'b0 || bus.rs2_o !== 5'd4 || bus.valid_o !== 1'b0) begin
      n_fail++; $display("FAIL invalid_ctl reg_wr=%b jump=%b rs2=%0d valid=%b want 0/0/4/0",
                         bus.reg_wr_o, bus.jump_o, bus.rs2_o, bus.valid_o);
    end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    bus.valid_i = 1; bus.reg_wr_i = 1; bus.rd_i = 5'd12; bus.pc_i = 32'h200;
    bubble_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_b++;
      n_run++;
      if (bus.rd_o !== 5'd0 || bus.valid_o !== 1'b0) begin
        n_fail++; $display("FAIL b2b_bubble[%0d] rd=%0d valid=%b want 0/0", i, bus.rd_o, bus.valid_o);
      end
    end
    n_run++;
    if (bubble_cnt_o !== (PERF ? exp_b : 16'h0)) begin
      n_fail++; $display("FAIL b2b_cnt got %0d want %0d", bubble_cnt_o, PERF ? exp_b : 16'h0);
    end
    bubble_i = 0;
    tick();
    n_run++;
    if (bus.rd_o !== 5'd12 || bus.pc_o !== 32'h200) begin
      n_fail++; $display("FAIL b2b_reload rd=%0d pc=%h want 12/200", bus.rd_o, bus.pc_o);
    end
  endtask

  task automatic test_reset_mid();
    hold_i = 1; reset_i = 1;
    tick();
    n_run++;
    if (out_vec !== '0 || bubble_cnt_o !== 16'h0 || flush_cnt_o !== 16'h0) begin
      n_fail++; $display("FAIL reset_mid out=%h cnt=%0d/%0d want 0/0/0", out_vec, bubble_cnt_o, flush_cnt_o);
    end
    hold_i = 0; reset_i = 0;
    exp_b = 0; exp_f = 0;
    tick();
    n_run++;
    if (bus.rd_o !== 5'd12 || bus.valid_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_release rd=%0d valid=%b want 12/1", bus.rd_o, bus.valid_o);
    end
  endtask

  task automatic test_saturation();
    bubble_i = 1;
    repeat (70000) @(posedge clk_i);
    #1;
    n_run++;
    if (bubble_cnt_o !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_reach got %h want ffff", bubble_cnt_o);
    end
    tick();
    tick();
    n_run++;
    if (bubble_cnt_o !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_hold got %h want ffff", bubble_cnt_o);
    end
    bubble_i = 0; reset_i = 1;
    tick();
    n_run++;
    if (bubble_cnt_o !== 16'h0) begin
      n_fail++; $display("FAIL sat_reset got %h want 0", bubble_cnt_o);
    end
    reset_i = 0;
  endtask

  initial begin
    reset_i = 1; bubble_i = 0; flush_i = 0; hold_i = 0;
    exp_b = 0; exp_f = 0;
    clear_inputs();
    #2;
    test_reset();
    test_load();
    test_bubble();
    test_hold_bubble();
    test_hold_flush();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    if (PERF) test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
